// File: rtl/counter_pkg.sv
// Shared constants and parameter legality check for counter_param.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // True when the parameter set describes a realisable counter:
   // 1 <= STEP <= MAX < 2**WIDTH, WIDTH >= 2, known mode, non-empty wrap counter.
   function automatic bit params_ok(input int width, input int step, input int max,
                                    input int sat_mode, input int wrap_w);
      longint lim;
      lim = longint'(1) << width;
      return (width >= 2) && (step >= 1) && (step <= max) && (longint'(max) < lim) &&
             ((sat_mode == MODE_WRAP) || (sat_mode == MODE_SAT)) && (wrap_w >= 1);
   endfunction

endpackage

// File: rtl/counter_param_next.sv
// Combinational next-value logic: one step up or down from cnt, with either
// modulo-(MAX+1) wrap or saturation, plus the boundary-event flag.
module counter_param_next
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP     = 1,
   parameter int MAX      = 2**WIDTH-1,
   parameter int SAT_MODE = MODE_WRAP
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             dir,
   output logic [WIDTH-1:0] nxt,
   output logic             bnd
);

   localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
   // MAX+1-STEP always fits WIDTH bits; wrapping either way is a modular
   // add/subtract of this gap, so no WIDTH+1 result is ever truncated.
   localparam logic [WIDTH-1:0] GAP_V  = WIDTH'(MAX + 1 - STEP);

   logic [WIDTH:0] sum;
   logic           ovf;
   logic           unf;

   // Step, detect crossing of the range ends, then wrap or clamp.
   always_comb begin
      sum = {1'b0, cnt} + {1'b0, STEP_V};
      ovf = (sum > MAX_X);
      unf = (cnt < STEP_V);
      nxt = cnt;
      bnd = 1'b0;
      if (dir == DIR_UP) begin
         if (!ovf)                    nxt = sum[WIDTH-1:0];
         else if (SAT_MODE == MODE_SAT) nxt = MAX_V;
         else                         nxt = cnt - GAP_V;
         // Saturation flags only the arrival at MAX, not sitting on it.
         if (SAT_MODE == MODE_SAT) bnd = (nxt == MAX_V) && (cnt != MAX_V);
         else                      bnd = ovf;
      end else begin
         if (!unf)                    nxt = cnt - STEP_V;
         else if (SAT_MODE == MODE_SAT) nxt = '0;
         else                         nxt = cnt + GAP_V;
         if (SAT_MODE == MODE_SAT) bnd = (nxt == '0) && (cnt != '0);
         else                      bnd = unf;
      end
   end

endmodule

// File: rtl/counter_param.sv
// Parametrised up/down event/timebase counter with wrap or saturate mode,
// synchronous clear/load, enable gating and a registered terminal-count pulse.
// Optional macro COUNTER_PARAM_WRAP_CNT_EN adds the wrap_cnt event counter.
module counter_param
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP     = 1,
   parameter int MAX      = 2**WIDTH-1,
   parameter int SAT_MODE = MODE_WRAP,
   parameter int WRAP_W   = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              dir,
   input  logic              clr,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  cnt,
   output logic              tc
`ifdef COUNTER_PARAM_WRAP_CNT_EN
   ,
   output logic [WRAP_W-1:0] wrap_cnt
`endif
);

   if (!params_ok(WIDTH, STEP, MAX, SAT_MODE, WRAP_W)) begin : g_param_err
      $error("counter_param: illegal WIDTH/STEP/MAX/SAT_MODE/WRAP_W");
   end

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] step_nxt;
   logic             step_bnd;
   logic [WIDTH-1:0] cnt_d;
   logic             tc_d;

   counter_param_next #(
      .WIDTH    (WIDTH),
      .STEP     (STEP),
      .MAX      (MAX),
      .SAT_MODE (SAT_MODE)
   ) u_next (
      .cnt (cnt),
      .dir (dir),
      .nxt (step_nxt),
      .bnd (step_bnd)
   );

   // Command priority: clear, then load (clamped to MAX), then enabled step.
   always_comb begin
      cnt_d = cnt;
      tc_d  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
      end else if (en) begin
         cnt_d = step_nxt;
         tc_d  = step_bnd;
      end
   end

   // Count and terminal-count registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
         tc  <= 1'b0;
      end else begin
         cnt <= cnt_d;
         tc  <= tc_d;
      end
   end

`ifdef COUNTER_PARAM_WRAP_CNT_EN
   // Boundary-event tally: counts every tc, sticks at all-ones, reset-only clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                        wrap_cnt <= '0;
      else if (tc_d && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_counter_param.sv
// Directed bench for counter_param: four instances cover binary roll-over,
// non-power-of-two wrap with STEP>1, saturation, command priority, clamped
// load, asynchronous reset and (when built with the macro) wrap_cnt.
module tb_counter_param;
   import counter_pkg::*;

   int checks = 0;
   int errors = 0;

   logic clk, rstn;

   logic       en0, dir0, clr0, load0;
   logic [2:0] lv0, cnt0;
   logic       tc0;

   logic       en1, dir1, clr1, load1;
   logic [3:0] lv1, cnt1;
   logic       tc1;

   logic       en2, dir2, clr2, load2;
   logic [3:0] lv2, cnt2;
   logic       tc2;

   logic       en3, dir3, clr3, load3;
   logic [2:0] lv3, cnt3;
   logic       tc3;
`ifdef COUNTER_PARAM_WRAP_CNT_EN
   logic [1:0] wc3;
`endif

   counter_param #(.WIDTH(3), .STEP(1), .MAX(7), .SAT_MODE(MODE_WRAP)) u0 (
      .clk(clk), .rstn(rstn), .en(en0), .dir(dir0), .clr(clr0), .load(load0),
      .load_val(lv0), .cnt(cnt0), .tc(tc0));

   counter_param #(.WIDTH(4), .STEP(3), .MAX(9), .SAT_MODE(MODE_WRAP)) u1 (
      .clk(clk), .rstn(rstn), .en(en1), .dir(dir1), .clr(clr1), .load(load1),
      .load_val(lv1), .cnt(cnt1), .tc(tc1));

   counter_param #(.WIDTH(4), .STEP(4), .MAX(10), .SAT_MODE(MODE_SAT)) u2 (
      .clk(clk), .rstn(rstn), .en(en2), .dir(dir2), .clr(clr2), .load(load2),
      .load_val(lv2), .cnt(cnt2), .tc(tc2));

   counter_param #(.WIDTH(3), .STEP(1), .MAX(7), .SAT_MODE(MODE_WRAP), .WRAP_W(2)) u3 (
      .clk(clk), .rstn(rstn), .en(en3), .dir(dir3), .clr(clr3), .load(load3),
      .load_val(lv3), .cnt(cnt3), .tc(tc3)
`ifdef COUNTER_PARAM_WRAP_CNT_EN
      , .wrap_cnt(wc3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int e0 [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
   int e1 [8]  = '{3, 6, 9, 2, 5, 2, 9, 6};
   bit t1 [8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
   int e2 [8]  = '{4, 8, 10, 10, 6, 2, 0, 0};
   bit t2 [8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
   int ew [5]  = '{1, 2, 3, 3, 3};

   initial begin
      rstn = 1'b0;
      {en0, dir0, clr0, load0} = '0; lv0 = '0;
      {en1, dir1, clr1, load1} = '0; lv1 = '0;
      {en2, dir2, clr2, load2} = '0; lv2 = '0;
      {en3, dir3, clr3, load3} = '0; lv3 = '0;

      // Reset state, held across an edge.
      #12;
      chk("rst_cnt0", 32'(cnt0), 0);
      chk("rst_tc0",  32'(tc0),  0);
      chk("rst_cnt1", 32'(cnt1), 0);
      chk("rst_cnt2", 32'(cnt2), 0);

      // W3 binary roll-over, first step on the first edge after release.
      en0 = 1'b1; dir0 = DIR_UP;
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("roll_cnt%0d", i), 32'(cnt0), 32'(e0[i]));
         chk($sformatf("roll_tc%0d", i),  32'(tc0),  (i == 7) ? 1 : 0);
      end
      en0 = 1'b0;

      // STEP=3, MAX=9 wrap up then down.
      en1 = 1'b1; dir1 = DIR_UP;
      for (int i = 0; i < 8; i++) begin
         if (i == 5) dir1 = DIR_DOWN;
         step();
         chk($sformatf("mod9_cnt%0d", i), 32'(cnt1), 32'(e1[i]));
         chk($sformatf("mod9_tc%0d", i),  32'(tc1),  32'(t1[i]));
      end

      // clr beats load beats en; then clamped load; then hold.
      clr1 = 1'b1; load1 = 1'b1; lv1 = 4'd7; en1 = 1'b1;
      step();
      chk("prio_cnt", 32'(cnt1), 0);
      chk("prio_tc",  32'(tc1),  0);
      clr1 = 1'b0; lv1 = 4'd15;
      step();
      chk("clamp_cnt", 32'(cnt1), 9);
      load1 = 1'b0; en1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("hold_cnt%0d", i), 32'(cnt1), 9);
         chk($sformatf("hold_tc%0d", i),  32'(tc1),  0);
      end

      // Saturation at MAX=10 and 0, single tc on arrival.
      en2 = 1'b1; dir2 = DIR_UP;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) dir2 = DIR_DOWN;
         step();
         chk($sformatf("sat_cnt%0d", i), 32'(cnt2), 32'(e2[i]));
         chk($sformatf("sat_tc%0d", i),  32'(tc2),  32'(t2[i]));
      end
      en2 = 1'b0;

      // Forced wraps: load 7 then step up once, five times.
      dir3 = DIR_UP;
      for (int i = 0; i < 5; i++) begin
         load3 = 1'b1; lv3 = 3'd7; en3 = 1'b0;
         step();
         load3 = 1'b0; en3 = 1'b1;
         step();
         chk($sformatf("fw_cnt%0d", i), 32'(cnt3), 0);
         chk($sformatf("fw_tc%0d", i),  32'(tc3),  1);
`ifdef COUNTER_PARAM_WRAP_CNT_EN
         chk($sformatf("wrap_cnt%0d", i), 32'(wc3), 32'(ew[i]));
`endif
      end
      en3 = 1'b0; clr3 = 1'b1;
      step();
      chk("clr3_cnt", 32'(cnt3), 0);
`ifdef COUNTER_PARAM_WRAP_CNT_EN
      chk("wrap_cnt_clr", 32'(wc3), 3);
`endif
      clr3 = 1'b0;

      // Asynchronous reset mid-cycle at cnt0=5 (u0 is at 2).
      en0 = 1'b1; dir0 = DIR_UP;
      step(); step(); step();
      chk("pre_rst_cnt0", 32'(cnt0), 5);
      #2 rstn = 1'b0;
      #1;
      chk("arst_cnt0", 32'(cnt0), 0);
      chk("arst_tc0",  32'(tc0),  0);
      chk("arst_cnt1", 32'(cnt1), 0);
`ifdef COUNTER_PARAM_WRAP_CNT_EN
      chk("arst_wrap_cnt", 32'(wc3), 0);
`endif
      #2 rstn = 1'b1;
      step();
      chk("resume_cnt0", 32'(cnt0), 1);
      chk("resume_tc0",  32'(tc0),  0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
Parametrised up/down counter that generalises the team's fixed 3-bit free-running counter. It adds width, step, terminal value, a wrap or saturate mode, synchronous clear and load, enable gating, and a terminal-count pulse. It is used as the common event/timebase counter in the datapath and replaces the fixed-width counters.

Parameters:
WIDTH, 8, counter width in bits (>=2).
STEP, 1, increment/decrement per enabled cycle (1 <= STEP <= MAX).
MAX, 2**WIDTH-1, terminal value; counter range is 0..MAX (MAX <= 2**WIDTH-1).
SAT_MODE, 0, 0 = modulo-(MAX+1) wrap; 1 = saturate at 0 / MAX.
WRAP_W, 16, width of wrap event counter (optional feature).

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset, asynchronous, active-low.
en  in  1  count enable; one step per cycle while high.
dir  in  1  1 = up, 0 = down.
clr  in  1  synchronous clear to 0.
load  in  1  synchronous load of load_val.
load_val  in  WIDTH  value for load.
cnt  out  WIDTH  current count, registered.
tc  out  1  terminal-count pulse, registered.
wrap_cnt  out  WRAP_W  boundary event count (only with COUNTER_PARAM_WRAP_CNT_EN).

Behaviour:
- Reset: rstn low clears immediately, independent of clk: cnt=0, tc=0, wrap_cnt=0. The counter leaves reset at the first rising edge after rstn deasserts. Reset mid-count discards all state.
- Priority at each edge: clr > load > en > hold.
- clr: cnt<=0, tc<=0. wrap_cnt is unchanged.
- load: cnt<=min(load_val, MAX), tc<=0.
- en, up: sum=cnt+STEP, computed in WIDTH+1 bits.
  - sum<=MAX: cnt<=sum.
  - sum>MAX, wrap mode: cnt<=sum-(MAX+1), tc<=1.
  - sum>MAX, saturate mode: cnt<=MAX.
- en, down:
  - cnt>=STEP: cnt<=cnt-STEP.
  - cnt<STEP, wrap mode: cnt<=cnt+(MAX+1)-STEP, tc<=1.
  - cnt<STEP, saturate mode: cnt<=0.
- Saturate-mode tc: tc<=1 only on the step that moves cnt onto the limit from a non-limit value. Further enabled steps held at the limit give tc=0.
- tc is high for exactly one cycle per event and is 0 in every cycle without an event. Latency is one edge: tc appears together with the wrapped or limited cnt.
- en low or no command: cnt holds, tc<=0.
- dir is sampled only when en is high. A dir change takes effect on the same edge.
- Edge cases:
  - MAX=2**WIDTH-1 with STEP=1 in wrap mode is a plain binary roll-over.
  - A non-power-of-two MAX wraps modulo MAX+1.
  - load of a value above MAX clamps to MAX.
- No combinational path from inputs to outputs.

Optional Feature:
Macro COUNTER_PARAM_WRAP_CNT_EN.
- Defined: port wrap_cnt exists. It increments by 1 on every edge where tc is set. It saturates at all-ones and is cleared only by rstn.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package counter_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - MODE_WRAP=0 and MODE_SAT=1.
  - A checker function for the parameter legality rules (STEP<=MAX, MAX<2**WIDTH).
- Natural sub-module: counter_param_next, purely combinational. It takes cnt, dir and the parameters and returns the next value and a boundary flag. The top level keeps the registers and priority logic.

Test Plan:
- WIDTH=3, STEP=1, MAX=7, wrap mode, en=1, dir=1, 10 cycles after reset -> cnt 1..7,0,1,2. tc=1 only in the cycle cnt=0 follows 7.
- WIDTH=4, STEP=3, MAX=9, wrap mode, up from 0 -> cnt 3,6,9,2 (tc=1),5. Then dir=0 from 5 -> 2,9 (tc=1),6.
- SAT_MODE=1, WIDTH=4, STEP=4, MAX=10, up from 0 -> 4,8,10 (tc=1),10 (tc=0). Then down -> 6,2,0 (tc=1),0 (tc=0).
- Same edge clr=1, load=1, en=1 -> cnt=0. Then load=1 with load_val=15 (MAX=9) -> cnt=9. Then en=0 for 5 cycles -> cnt holds at 9, tc=0.
- Assert rstn low asynchronously mid-cycle at cnt=5 -> cnt=0 and tc=0 before the next edge. After release, count resumes from 0 at the first edge.
- With COUNTER_PARAM_WRAP_CNT_EN, WRAP_W=2, force 5 wraps -> wrap_cnt 1,2,3,3,3. Unchanged by clr. Zeroed by rstn.
